// File: rtl/apb_pkg.sv
// Shared types and default address map for the peripheral APB segment.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int          DEF_NUM_SLV       = 4;
  localparam logic [31:0] DEF_BASE_ADDR     = 32'h1000_0000;
  localparam int          DEF_SLV_SPAN_LOG2 = 12;
  localparam int          DEF_TIMEOUT       = 255;

  localparam logic [31:0] SLV0_BASE = DEF_BASE_ADDR + (32'd0 << DEF_SLV_SPAN_LOG2);
  localparam logic [31:0] SLV1_BASE = DEF_BASE_ADDR + (32'd1 << DEF_SLV_SPAN_LOG2);
  localparam logic [31:0] SLV2_BASE = DEF_BASE_ADDR + (32'd2 << DEF_SLV_SPAN_LOG2);
  localparam logic [31:0] SLV3_BASE = DEF_BASE_ADDR + (32'd3 << DEF_SLV_SPAN_LOG2);

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational window decode: byte address to {hit, slave index}.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV       = DEF_NUM_SLV,
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          SLV_SPAN_LOG2 = DEF_SLV_SPAN_LOG2,
  localparam int         IDX_W         = $clog2(NUM_SLV)
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);
  localparam int HI = SLV_SPAN_LOG2 + IDX_W;

  // Offset bits inside a slave window do not take part in the decode.
  logic unused_offset_bits;
  assign unused_offset_bits = ^addr_i[SLV_SPAN_LOG2-1:0];

  assign hit_o = (addr_i[31:HI] == BASE_ADDR[31:HI]);
  assign idx_o = addr_i[SLV_SPAN_LOG2 +: IDX_W];

endmodule

// File: rtl/apb_master.sv
// APB initiator: registers a core request, drives SETUP/ACCESS to the decoded
// slave, and returns a one-cycle ready with err on unmapped address or timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLV       = DEF_NUM_SLV,
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          SLV_SPAN_LOG2 = DEF_SLV_SPAN_LOG2,
  parameter int          TIMEOUT       = DEF_TIMEOUT
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               transfer,
  input  logic               write,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               err,
  output logic [31:0]        PADDR,
  output logic [31:0]        PWDATA,
  output logic               PWRITE,
  output logic               PENABLE,
  output logic [NUM_SLV-1:0] PSEL,
  input  logic [31:0]        PRDATA [NUM_SLV],
  input  logic [NUM_SLV-1:0] PREADY
);
  localparam int         IDX_W = $clog2(NUM_SLV);
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  apb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic               pwrite_q, pwrite_d, err_q, err_d;
  logic               ready_q, ready_d, penable_q, penable_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               sel_ready;
  logic [31:0]        sel_rdata;

  apb_addr_decoder #(
    .NUM_SLV      (NUM_SLV),
    .BASE_ADDR    (BASE_ADDR),
    .SLV_SPAN_LOG2(SLV_SPAN_LOG2)
  ) u_dec (
    .addr_i(addr),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  // Only the selected slave is observed, so X on idle slaves never propagates.
  assign sel_ready = PREADY[idx_q];
  assign sel_rdata = PRDATA[idx_q];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (dec_hit) begin
            state_d  = SETUP;
            idx_d    = dec_idx;
            cnt_d    = '0;
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = write;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (sel_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = pwrite_q ? 32'd0 : sel_rdata;
        end else if (cnt_d == TMO) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus controls are decoded from the next state so they come straight off flops.
  always_comb begin
    psel_d    = '0;
    penable_d = 1'b0;
    ready_d   = 1'b0;
    case (state_d)
      SETUP:  psel_d[idx_d] = 1'b1;
      ACCESS: begin
        psel_d[idx_d] = 1'b1;
        penable_d     = 1'b1;
      end
      RESP:   ready_d = 1'b1;
      default: ;
    endcase
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a per-cycle expectation timeline built from
// transfer-level rules, checked every falling edge, plus literal spot checks.
module tb_apb_master;
  localparam int MAXC = 256;
  localparam int TMO  = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer, write;
  logic [31:0] addr, wdata, rdata, PADDR, PWDATA;
  logic        ready, err, PWRITE, PENABLE;
  logic [3:0]  PSEL, pready;
  logic [31:0] prdata [4];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int wait_cfg = 0;
  bit chk_en = 1'b0;

  logic [3:0]  exp_psel   [MAXC];
  bit          exp_pen    [MAXC];
  bit          exp_ready  [MAXC];
  bit          exp_err    [MAXC];
  bit          exp_rdchk  [MAXC];
  logic [31:0] exp_rdata  [MAXC];
  logic [31:0] exp_paddr  [MAXC];
  logic [31:0] exp_pwdata [MAXC];
  bit          exp_pwrite [MAXC];

  apb_master #(
    .NUM_SLV      (4),
    .BASE_ADDR    (32'h1000_0000),
    .SLV_SPAN_LOG2(12),
    .TIMEOUT      (TMO)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (prdata),
    .PREADY  (pready)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: PREADY rises after wait_cfg low cycles of ACCESS.
  always @(posedge PCLK) acc_cnt <= ((|PSEL) && PENABLE) ? acc_cnt + 1 : 0;
  assign pready = {4{acc_cnt >= wait_cfg}};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic set_idle(input int c);
    exp_psel[c]  = 4'b0000;
    exp_pen[c]   = 1'b0;
    exp_ready[c] = 1'b0;
    exp_err[c]   = 1'b0;
    exp_rdchk[c] = 1'b0;
    exp_rdata[c] = '0;
  endtask

  // Transfer-level model: e is the cycle index of the first cycle after the
  // sampling edge; returns the cycle index of the ready pulse.
  task automatic plan(input int e, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input int w, input logic [31:0] rd, output int r);
    logic [31:0] base;
    int idx, acc;
    bit to;
    base = 32'h1000_0000;
    if (a[31:14] != base[31:14]) begin
      r = e;
      exp_ready[r] = 1'b1;
      exp_err[r]   = 1'b1;
      exp_rdchk[r] = 1'b1;
      exp_rdata[r] = '0;
      return;
    end
    idx = int'(a[13:12]);
    to  = (w >= TMO);
    acc = to ? TMO : w + 1;
    for (int k = 0; k <= acc; k++) begin
      exp_psel[e+k]   = 4'(1 << idx);
      exp_pen[e+k]    = (k != 0);
      exp_paddr[e+k]  = a;
      exp_pwdata[e+k] = wd;
      exp_pwrite[e+k] = wr;
    end
    r = e + acc + 1;
    exp_ready[r] = 1'b1;
    exp_err[r]   = to;
    exp_rdchk[r] = !wr || to;
    exp_rdata[r] = to ? 32'd0 : rd;
  endtask

  // Called at a falling edge; the next rising edge samples the request.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd, input int w,
                       input logic [31:0] rd, output int e, output int r);
    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = wd;
    wait_cfg = w;
    e = cyc + 1;
    plan(e, wr, a, wd, w, rd, r);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge PCLK);
  endtask

  always @(negedge PCLK) begin
    if (chk_en && !PRESET && cyc < MAXC) begin
      check("psel", 32'(PSEL), 32'(exp_psel[cyc]));
      check("penable", 32'(PENABLE), 32'(exp_pen[cyc]));
      check("ready", 32'(ready), 32'(exp_ready[cyc]));
      if (exp_ready[cyc]) check("err", 32'(err), 32'(exp_err[cyc]));
      if (exp_ready[cyc] && exp_rdchk[cyc]) check("rdata", rdata, exp_rdata[cyc]);
      if (exp_psel[cyc] != 4'b0000) begin
        check("paddr", PADDR, exp_paddr[cyc]);
        check("pwdata", PWDATA, exp_pwdata[cyc]);
        check("pwrite", 32'(PWRITE), 32'(exp_pwrite[cyc]));
      end
    end
  end

  initial begin
    int e, r, e1, r1;
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 4; i++) prdata[i] = 32'h0101_0101 * (i + 1);
    for (int c = 0; c < MAXC; c++) set_idle(c);
    #3;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge PCLK); PRESET = 1'b0; chk_en = 1'b1;
    @(negedge PCLK);

    // zero-wait write to slave 1
    issue(1'b1, 32'h1000_1004, 32'h0000_00A5, 0, 32'd0, e, r);
    check("wr_latency", 32'(r - e), 32'd2);
    goto(e);     check("wr_c1_psel", 32'(PSEL), 32'h2);  check("wr_c1_pen", 32'(PENABLE), 32'd0);
    goto(e + 1); check("wr_c2_psel", 32'(PSEL), 32'h2);  check("wr_c2_pen", 32'(PENABLE), 32'd1);
    goto(r);     check("wr_c3_ready", 32'(ready), 32'd1); check("wr_c3_err", 32'(err), 32'd0);
    transfer = 1'b0; @(negedge PCLK);

    // read with one wait cycle
    prdata[1] = 32'h0000_003C;
    issue(1'b0, 32'h1000_1008, 32'h0, 1, 32'h3C, e, r);
    check("rd1w_latency", 32'(r - e), 32'd3);
    goto(r); check("rd1w_ready", 32'(ready), 32'd1); check("rd1w_rdata", rdata, 32'h3C);
    transfer = 1'b0; @(negedge PCLK);

    // unmapped address
    issue(1'b0, 32'h2000_0000, 32'h55, 0, 32'd0, e, r);
    check("unmap_latency", 32'(r - e), 32'd0);
    goto(r); check("unmap_ready", 32'(ready), 32'd1); check("unmap_err", 32'(err), 32'd1);
    check("unmap_rdata", rdata, 32'd0);
    transfer = 1'b0; @(negedge PCLK);

    // stuck slave hits the timeout
    prdata[2] = 32'hDEAD_BEEF;
    issue(1'b0, 32'h1000_2000, 32'h0, 255, 32'd0, e, r);
    check("tmo_latency", 32'(r - e), 32'd5);
    goto(r); check("tmo_err", 32'(err), 32'd1); check("tmo_rdata", rdata, 32'd0);
    check("tmo_psel", 32'(PSEL), 32'd0); check("tmo_pen", 32'(PENABLE), 32'd0);
    transfer = 1'b0; @(negedge PCLK);

    // ready in the last allowed ACCESS cycle is not a timeout
    prdata[3] = 32'h1234_5678;
    issue(1'b0, 32'h1000_3000, 32'h0, TMO - 1, 32'h1234_5678, e, r);
    goto(r); check("edge_err", 32'(err), 32'd0); check("edge_rdata", rdata, 32'h1234_5678);
    transfer = 1'b0; @(negedge PCLK);

    // back-to-back to slaves 0 and 3 with X on slaves 1 and 2
    prdata[1] = 'x; prdata[2] = 'x;
    prdata[0] = 32'hCAFE_0000; prdata[3] = 32'h0000_BEEF;
    issue(1'b0, 32'h1000_0010, 32'h0, 0, 32'hCAFE_0000, e1, r1);
    goto(r1); check("b2b_rdata0", rdata, 32'hCAFE_0000);
    @(negedge PCLK);
    issue(1'b0, 32'h1000_3020, 32'h0, 0, 32'h0000_BEEF, e, r);
    check("b2b_setup_gap", 32'(e - e1), 32'd4);
    goto(e); check("b2b_psel", 32'(PSEL), 32'h8);
    goto(r); check("b2b_rdata1", rdata, 32'h0000_BEEF);
    transfer = 1'b0; @(negedge PCLK);
    prdata[1] = 32'h0202_0202; prdata[2] = 32'h0303_0303;

    // reset during ACCESS abandons the transfer
    prdata[0] = 32'h0F0F_0F0F;
    issue(1'b0, 32'h1000_0000, 32'h0, 2, 32'h0F0F_0F0F, e, r);
    goto(e + 1);
    #2 PRESET = 1'b1; transfer = 1'b0;
    #1;
    check("arst_psel", 32'(PSEL), 32'd0);
    check("arst_pen", 32'(PENABLE), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_rdata", rdata, 32'd0);
    for (int c = e + 2; c < e + 20; c++) set_idle(c);
    @(negedge PCLK); PRESET = 1'b0;
    @(negedge PCLK);

    prdata[0] = 32'h600D_F00D;
    issue(1'b0, 32'h1000_0000, 32'h0, 0, 32'h600D_F00D, e, r);
    check("post_rst_latency", 32'(r - e), 32'd2);
    goto(r); check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_rdata", rdata, 32'h600D_F00D); check("post_rst_err", 32'(err), 32'd0);
    transfer = 1'b0;
    repeat (3) @(negedge PCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
